// File: rtl/dm9000a_init_seq.sv
// rtl/dm9000a_init_seq.sv - DM9000A power-up register/delay sequencer
module dm9000a_init_seq #(
   parameter logic [47:0] MAC_ADDR     = 48'h00_60_6E_90_00_AE,
   parameter logic [10:0] PHY_DELAY_US = 11'd1000,
   parameter logic [10:0] RST_DELAY_US = 11'd20,
   parameter logic [23:0] TIMEOUT_CYC  = 24'd65535
) (
   input  logic        iDm9000aClk,
   input  logic        iRunStart,
   input  logic        in_from_Dm9000a_iow_RunEnd,
   input  logic        in_from_Dm9000a_usDelay_RunEnd,
   output logic        out_to_Dm9000a_iow_RunStart,
   output logic [15:0] out_to_Dm9000a_iow_Reg,
   output logic [15:0] out_to_Dm9000a_iow_Data,
   output logic        out_to_Dm9000a_usDelay_RunStart,
   output logic [10:0] out_to_Dm9000a_usDelay_DelayTime,
   output logic [4:0]  oStepIndex,
   output logic        oRunEnd,
   output logic        oError
);

   typedef enum logic [4:0] {
      IDLE = 5'b00001,
      REQ  = 5'b00010,
      REL  = 5'b00100,
      DONE = 5'b01000,
      ERR  = 5'b10000
   } state_t;

   localparam logic [4:0] LAST_STEP = 5'd18;

   state_t      state, stateNext;
   logic [4:0]  stepIdx, stepIdxNext;
   logic [23:0] toCnt, toCntNext;
   logic        armed, armedNext;

   logic        stepIsDelay;
   logic [15:0] stepReg;
   logic [15:0] stepData;
   logic [10:0] stepDelay;
   logic        stepRunEnd;

   logic        wrRunNext;
   logic        dlyRunNext;
   logic [15:0] regNext;
   logic [15:0] dataNext;
   logic [10:0] delayNext;
   logic [4:0]  idxOutNext;
   logic        runEndNext;
   logic        errorNext;

   // Step table: operands for the step currently addressed by stepIdx
   always_comb begin
      stepIsDelay = 1'b0;
      stepReg     = 16'h0000;
      stepData    = 16'h0000;
      stepDelay   = 11'd0;
      case (stepIdx)
         5'd0:  begin stepReg = 16'h001E; stepData = 16'h0001; end
         5'd1:  begin stepReg = 16'h001F; stepData = 16'h0000; end
         5'd2:  begin stepIsDelay = 1'b1; stepDelay = PHY_DELAY_US; end
         5'd3:  begin stepReg = 16'h0000; stepData = 16'h0003; end
         5'd4:  begin stepIsDelay = 1'b1; stepDelay = RST_DELAY_US; end
         5'd5:  begin stepReg = 16'h0000; stepData = 16'h0000; end
         5'd6:  begin stepReg = 16'h0000; stepData = 16'h0003; end
         5'd7:  begin stepIsDelay = 1'b1; stepDelay = RST_DELAY_US; end
         5'd8:  begin stepReg = 16'h0000; stepData = 16'h0000; end
         5'd9:  begin stepReg = 16'h0001; stepData = 16'h002C; end
         5'd10: begin stepReg = 16'h00FE; stepData = 16'h003F; end
         5'd11: begin stepReg = 16'h0010; stepData = {8'h00, MAC_ADDR[47:40]}; end
         5'd12: begin stepReg = 16'h0011; stepData = {8'h00, MAC_ADDR[39:32]}; end
         5'd13: begin stepReg = 16'h0012; stepData = {8'h00, MAC_ADDR[31:24]}; end
         5'd14: begin stepReg = 16'h0013; stepData = {8'h00, MAC_ADDR[23:16]}; end
         5'd15: begin stepReg = 16'h0014; stepData = {8'h00, MAC_ADDR[15:8]}; end
         5'd16: begin stepReg = 16'h0015; stepData = {8'h00, MAC_ADDR[7:0]}; end
         5'd17: begin stepReg = 16'h00FF; stepData = 16'h0080; end
         5'd18: begin stepReg = 16'h0005; stepData = 16'h0039; end
         default: begin stepReg = 16'h0000; stepData = 16'h0000; end
      endcase
   end

   // Only the engine that owns the current step may complete it
   assign stepRunEnd = stepIsDelay ? in_from_Dm9000a_usDelay_RunEnd
                                   : in_from_Dm9000a_iow_RunEnd;

   // Next-state logic and the output values the current state asks for
   always_comb begin
      stateNext   = state;
      stepIdxNext = stepIdx;
      toCntNext   = toCnt;
      armedNext   = armed;
      wrRunNext   = 1'b0;
      dlyRunNext  = 1'b0;
      regNext     = 16'h0000;
      dataNext    = 16'h0000;
      delayNext   = 11'd0;
      idxOutNext  = stepIdx;
      runEndNext  = 1'b0;
      errorNext   = 1'b0;
      case (state)
         IDLE: begin
            // One settling cycle after the run level is first seen
            if (!armed) begin
               armedNext = 1'b1;
            end else begin
               armedNext   = 1'b0;
               stepIdxNext = 5'd0;
               toCntNext   = 24'd0;
               stateNext   = REQ;
            end
         end
         REQ: begin
            if (stepIsDelay) begin
               dlyRunNext = 1'b1;
               delayNext  = stepDelay;
            end else begin
               wrRunNext = 1'b1;
               regNext   = stepReg;
               dataNext  = stepData;
            end
            if (stepRunEnd) begin
               stateNext = REL;
            end else if (!stepIsDelay) begin
               if (toCnt >= TIMEOUT_CYC) begin
                  stateNext = ERR;
               end else begin
                  toCntNext = toCnt + 24'd1;
               end
            end
         end
         REL: begin
            // Engine run lines drop for this one cycle, resetting the engine
            toCntNext = 24'd0;
            if (stepIdx == LAST_STEP) begin
               stateNext = DONE;
            end else begin
               stepIdxNext = stepIdx + 5'd1;
               stateNext   = REQ;
            end
         end
         DONE: begin
            runEndNext = 1'b1;
         end
         ERR: begin
            runEndNext = 1'b1;
            errorNext  = 1'b1;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, step index and timeout counter
   always_ff @(posedge iDm9000aClk or negedge iRunStart) begin
      if (!iRunStart) begin
         state   <= IDLE;
         stepIdx <= 5'd0;
         toCnt   <= 24'd0;
         armed   <= 1'b0;
      end else begin
         state   <= stateNext;
         stepIdx <= stepIdxNext;
         toCnt   <= toCntNext;
         armed   <= armedNext;
      end
   end

   // Registered outputs, one cycle behind the state that produced them
   always_ff @(posedge iDm9000aClk or negedge iRunStart) begin
      if (!iRunStart) begin
         out_to_Dm9000a_iow_RunStart      <= 1'b0;
         out_to_Dm9000a_iow_Reg           <= 16'h0000;
         out_to_Dm9000a_iow_Data          <= 16'h0000;
         out_to_Dm9000a_usDelay_RunStart  <= 1'b0;
         out_to_Dm9000a_usDelay_DelayTime <= 11'd0;
         oStepIndex                       <= 5'd0;
         oRunEnd                          <= 1'b0;
         oError                           <= 1'b0;
      end else begin
         out_to_Dm9000a_iow_RunStart      <= wrRunNext;
         out_to_Dm9000a_iow_Reg           <= regNext;
         out_to_Dm9000a_iow_Data          <= dataNext;
         out_to_Dm9000a_usDelay_RunStart  <= dlyRunNext;
         out_to_Dm9000a_usDelay_DelayTime <= delayNext;
         oStepIndex                       <= idxOutNext;
         oRunEnd                          <= runEndNext;
         oError                           <= errorNext;
      end
   end

endmodule

// File: tb/tb_dm9000a_init_seq.sv
// tb/tb_dm9000a_init_seq.sv - scoreboard bench for dm9000a_init_seq
`timescale 1ns/1ps
module tb_dm9000a_init_seq;

   localparam logic [47:0] MAC  = 48'hAABBCCDDEEFF;
   localparam logic [10:0] PHYD = 11'd1000;
   localparam logic [10:0] RSTD = 11'd20;
   localparam int          TMO  = 100;

   logic        clk = 1'b0;
   logic        runStart;
   logic        wrEnd, dlyEnd;
   logic        wrRS, dlyRS;
   logic [15:0] oReg, oData;
   logic [10:0] oDly;
   logic [4:0]  oStepIndex;
   logic        oRunEnd, oError;

   always #5 clk = ~clk;

   dm9000a_init_seq #(
      .MAC_ADDR(MAC), .PHY_DELAY_US(PHYD), .RST_DELAY_US(RSTD), .TIMEOUT_CYC(24'(TMO))
   ) dut (
      .iDm9000aClk(clk),
      .iRunStart(runStart),
      .in_from_Dm9000a_iow_RunEnd(wrEnd),
      .in_from_Dm9000a_usDelay_RunEnd(dlyEnd),
      .out_to_Dm9000a_iow_RunStart(wrRS),
      .out_to_Dm9000a_iow_Reg(oReg),
      .out_to_Dm9000a_iow_Data(oData),
      .out_to_Dm9000a_usDelay_RunStart(dlyRS),
      .out_to_Dm9000a_usDelay_DelayTime(oDly),
      .oStepIndex(oStepIndex),
      .oRunEnd(oRunEnd),
      .oError(oError)
   );

   int nChecks = 0;
   int nFail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- engine models ----------------
   int   lat [0:18];
   bit   forceWr = 1'b0;
   bit   wrSilent = 1'b0;
   int   silentStep = 0;
   int   wrCnt, dlyCnt;
   logic wrDone, dlyDone;
   int   curLat;
   logic wrMute;
   int   edgeCnt = 0;

   always_comb curLat = (oStepIndex <= 5'd18) ? lat[oStepIndex] : 1;
   always_comb wrMute = wrSilent && (int'(oStepIndex) == silentStep);

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   always @(posedge clk) begin
      if (!wrRS) begin
         wrCnt  <= 0;
         wrDone <= 1'b0;
      end else begin
         wrCnt <= wrCnt + 1;
         if (wrCnt + 1 >= curLat && !wrMute) wrDone <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (!dlyRS) begin
         dlyCnt  <= 0;
         dlyDone <= 1'b0;
      end else begin
         dlyCnt <= dlyCnt + 1;
         if (dlyCnt + 1 >= curLat) dlyDone <= 1'b1;
      end
   end

   assign wrEnd  = (wrRS && !wrMute && (wrDone || curLat == 0)) || (forceWr && dlyRS);
   assign dlyEnd = dlyRS && (dlyDone || curLat == 0);

   // ---------------- reference model ----------------
   typedef struct {
      bit          isDly;
      logic [15:0] rg;
      logic [15:0] dt;
      logic [10:0] dl;
      int          step;
      int          dur;
      bit          err;
   } exp_t;

   exp_t expQ[$];

   function automatic logic [7:0] macByte(input int k);
      logic [47:0] m;
      m = MAC;
      return m[47 - 8*k -: 8];
   endfunction

   function automatic exp_t refStep(input int s);
      exp_t e;
      e.isDly = 1'b0; e.rg = 16'h0; e.dt = 16'h0; e.dl = 11'd0;
      e.step = s; e.dur = 0; e.err = 1'b0;
      if (s == 2) begin
         e.isDly = 1'b1; e.dl = PHYD;
      end else if (s == 4 || s == 7) begin
         e.isDly = 1'b1; e.dl = RSTD;
      end else if (s >= 11 && s <= 16) begin
         e.rg = 16'h0010 + 16'(s - 11);
         e.dt = {8'h00, macByte(s - 11)};
      end else begin
         case (s)
            0:  begin e.rg = 16'h001E; e.dt = 16'h0001; end
            1:  begin e.rg = 16'h001F; e.dt = 16'h0000; end
            3:  begin e.rg = 16'h0000; e.dt = 16'h0003; end
            6:  begin e.rg = 16'h0000; e.dt = 16'h0003; end
            9:  begin e.rg = 16'h0001; e.dt = 16'h002C; end
            10: begin e.rg = 16'h00FE; e.dt = 16'h003F; end
            17: begin e.rg = 16'h00FF; e.dt = 16'h0080; end
            18: begin e.rg = 16'h0005; e.dt = 16'h0039; end
            default: begin e.rg = 16'h0000; e.dt = 16'h0000; end
         endcase
      end
      return e;
   endfunction

   // Queue one full run; a request stays up for its answer latency + 2 cycles,
   // a timed-out write for TIMEOUT+1 cycles, and the run ends there
   task automatic pushRun(input int errStep);
      exp_t e;
      for (int s = 0; s < 19; s++) begin
         e = refStep(s);
         if (s == errStep) begin
            e.dur = TMO + 1;
            e.err = 1'b1;
            expQ.push_back(e);
            break;
         end
         e.dur = lat[s] + 2;
         expQ.push_back(e);
      end
   endtask

   // ---------------- monitor ----------------
   bit          active = 1'b0;
   bit          seenOne = 1'b0;
   bit          stableBad;
   bit          lastErr = 1'b0;
   logic        prevRunEnd = 1'b0;
   int          highLen, lowLen = 0;
   int          lastFallEdge = 0;
   int          startEdge = 0;
   exp_t        cur;
   logic [15:0] capReg, capData;
   logic [10:0] capDly;
   logic [4:0]  capIdx;
   logic        capWr, capDlyRS;

   always @(negedge clk) begin
      if (!runStart) begin
         active = 1'b0; seenOne = 1'b0; lowLen = 0; prevRunEnd = 1'b0;
      end else begin
         if ((wrRS || dlyRS) && !active) begin
            active = 1'b1; highLen = 1; stableBad = 1'b0;
            if (!seenOne) check("start_latency", 32'(edgeCnt - startEdge), 32'd2);
            else          check("gap_low_cycles", 32'(lowLen), 32'd1);
            if (expQ.size() == 0) begin
               check("unexpected_request", 32'(oStepIndex), 32'hFFFF);
               cur = refStep(0);
            end else begin
               cur = expQ.pop_front();
               check("req_kind", 32'({wrRS, dlyRS}), cur.isDly ? 32'd1 : 32'd2);
               check("req_step", 32'(oStepIndex), 32'(cur.step));
               check("req_reg", 32'(oReg), 32'(cur.rg));
               check("req_data", 32'(oData), 32'(cur.dt));
               check("req_delay", 32'(oDly), 32'(cur.dl));
            end
            capReg = oReg; capData = oData; capDly = oDly; capIdx = oStepIndex;
            capWr = wrRS; capDlyRS = dlyRS;
         end else if ((wrRS || dlyRS) && active) begin
            highLen++;
            if (oReg !== capReg || oData !== capData || oDly !== capDly ||
                oStepIndex !== capIdx || wrRS !== capWr || dlyRS !== capDlyRS)
               stableBad = 1'b1;
         end else if (active) begin
            active = 1'b0; seenOne = 1'b1; lowLen = 1;
            check("req_duration", 32'(highLen), 32'(cur.dur));
            check("operands_stable", 32'(stableBad), 32'd0);
            check("error_flag", 32'(oError), 32'(cur.err));
            lastFallEdge = edgeCnt;
            lastErr = cur.err;
         end else begin
            lowLen++;
         end
         if (oRunEnd && !prevRunEnd)
            check("runend_latency", 32'(edgeCnt - lastFallEdge), lastErr ? 32'd0 : 32'd1);
         prevRunEnd = oRunEnd;
      end
   end

   // ---------------- stimulus ----------------
   task automatic randLats();
      for (int s = 0; s < 19; s++) lat[s] = $urandom_range(0, 6);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_iow_runstart"}, 32'(wrRS), 32'd0);
      check({tag, "_dly_runstart"}, 32'(dlyRS), 32'd0);
      check({tag, "_reg"}, 32'(oReg), 32'd0);
      check({tag, "_data"}, 32'(oData), 32'd0);
      check({tag, "_delay"}, 32'(oDly), 32'd0);
      check({tag, "_step"}, 32'(oStepIndex), 32'd0);
      check({tag, "_runend"}, 32'(oRunEnd), 32'd0);
      check({tag, "_error"}, 32'(oError), 32'd0);
   endtask

   task automatic startRun();
      @(posedge clk); #2;
      runStart  = 1'b1;
      startEdge = edgeCnt + 1;
   endtask

   task automatic stopRun(input string tag);
      @(posedge clk); #2;
      runStart = 1'b0;
      #1;
      checkAllZero(tag);
      expQ.delete();
      repeat (3) @(posedge clk);
   endtask

   task automatic waitRunEnd(input int limit, input string name);
      int n = 0;
      while (!oRunEnd && n < limit) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check(name, 32'(oRunEnd), 32'd1);
   endtask

   task automatic checkFinal(input string tag, input bit err, input int step);
      check({tag, "_runend"}, 32'(oRunEnd), 32'd1);
      check({tag, "_error"}, 32'(oError), 32'(err));
      check({tag, "_step"}, 32'(oStepIndex), 32'(step));
      check({tag, "_runstarts"}, 32'({wrRS, dlyRS}), 32'd0);
      check({tag, "_queue_left"}, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      int n;
      runStart = 1'b0;
      randLats();
      repeat (3) @(negedge clk);
      checkAllZero("reset");

      // Run A: full table, long PHY delay while the write engine's flag is forced high
      randLats();
      lat[2]  = 500;
      forceWr = 1'b1;
      pushRun(-1);
      startRun();
      waitRunEnd(3000, "runA_finished");
      checkFinal("runA", 1'b0, 18);
      forceWr = 1'b0;
      repeat (5) @(negedge clk);
      check("runA_done_held", 32'({oRunEnd, oError}), 32'd2);
      stopRun("stopA");

      // Run B: abort in the middle of step 12, then full replay
      randLats();
      lat[12] = 30;
      pushRun(-1);
      startRun();
      n = 0;
      while (!(oStepIndex == 5'd12 && wrRS) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("runB_reach_step12", 32'({oStepIndex, wrRS}), 32'({5'd12, 1'b1}));
      repeat (3) @(negedge clk);
      stopRun("abortB");
      randLats();
      pushRun(-1);
      startRun();
      waitRunEnd(3000, "runB_finished");
      checkFinal("runB", 1'b0, 18);
      stopRun("stopB");

      // Run C: write engine never answers at step 5
      randLats();
      wrSilent   = 1'b1;
      silentStep = 5;
      pushRun(5);
      startRun();
      waitRunEnd(3000, "runC_finished");
      checkFinal("runC", 1'b1, 5);
      repeat (10) @(negedge clk);
      check("runC_err_held", 32'({oRunEnd, oError, oStepIndex}), 32'({1'b1, 1'b1, 5'd5}));
      wrSilent = 1'b0;
      stopRun("stopC");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
